// File: rtl/jtag_master.sv
// JTAG host engine: walks the TAP from Run-Test/Idle through IR/DR scans, TLR or idle spins
// and back, one TCK slot of 2*TCK_DIV clk cycles at a time, returning the captured TDO bits.
module jtag_master #(
    parameter int MAX_LEN = 64,
    parameter int TCK_DIV = 4
) (
    input  logic                         clk,
    input  logic                         reset_,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [1:0]                   cmd_type,
    input  logic [$clog2(MAX_LEN+1)-1:0] cmd_len,
    input  logic [MAX_LEN-1:0]           cmd_tdi,
    output logic                         rsp_valid,
    output logic [MAX_LEN-1:0]           rsp_tdo,
    output logic                         busy,
    output logic                         tck,
    output logic                         tms,
    output logic                         tdi,
    input  logic                         tdo
);

    localparam int LW = $clog2(MAX_LEN+1);
    localparam int CW = (LW > 3) ? LW : 3;
    localparam int IW = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
    localparam int DW = $clog2(2*TCK_DIV);
    localparam logic [DW-1:0] DIV_SAMPLE = DW'(TCK_DIV-1);
    localparam logic [DW-1:0] DIV_HIGH   = DW'(TCK_DIV);
    localparam logic [DW-1:0] DIV_LAST   = DW'(2*TCK_DIV-1);

    localparam logic [1:0] T_IR   = 2'd0;
    localparam logic [1:0] T_TLR  = 2'd2;
    localparam logic [1:0] T_SPIN = 2'd3;

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_SHIFT, S_POST, S_RESP} state_t;

    state_t             state_q, state_d;
    logic [DW-1:0]      div_q, div_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [1:0]         type_q, type_d;
    logic [CW-1:0]      len_q, len_d;
    logic [MAX_LEN-1:0] tdi_q, tdi_d;
    logic [MAX_LEN-1:0] rsp_tdo_q, rsp_tdo_d;

    logic          is_scan, len_zero, slot_end, sample, tck_hi;
    logic [CW-1:0] len_c, pre_ones, phase_last;
    state_t        phase_next;

    assign is_scan  = ~type_q[1];
    assign len_zero = (len_q == '0);
    assign slot_end = (div_q == DIV_LAST);
    assign sample   = (div_q == DIV_SAMPLE);
    assign tck_hi   = (div_q >= DIV_HIGH);

    // Leading tms=1 slots of the prefix: Select-DR (+Select-IR) or the five TLR ones.
    always_comb begin
        pre_ones = CW'(1);
        if (type_q == T_TLR)     pre_ones = CW'(5);
        else if (type_q == T_IR) pre_ones = CW'(2);
    end

    always_comb begin
        len_c = CW'(cmd_len);
        if (cmd_len > LW'(MAX_LEN)) len_c = CW'(MAX_LEN);
    end

    // Last slot index and successor of the current slot-driven phase.
    always_comb begin
        phase_last = '0;
        phase_next = S_RESP;
        case (state_q)
            S_PRE: begin
                phase_last = (type_q == T_TLR || len_zero) ? pre_ones : pre_ones + 1'b1;
                if (type_q == T_TLR) phase_next = S_RESP;
                else if (len_zero)   phase_next = S_POST;
                else                 phase_next = S_SHIFT;
            end
            S_SHIFT: begin
                phase_last = len_q - 1'b1;
                phase_next = is_scan ? S_POST : S_RESP;
            end
            S_POST: begin
                phase_last = len_zero ? CW'(2) : CW'(1);
                phase_next = S_RESP;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset_) begin
        if (reset_) begin
            state_q   <= S_IDLE;
            div_q     <= '0;
            cnt_q     <= '0;
            type_q    <= '0;
            len_q     <= '0;
            tdi_q     <= '0;
            rsp_tdo_q <= '0;
        end else begin
            state_q   <= state_d;
            div_q     <= div_d;
            cnt_q     <= cnt_d;
            type_q    <= type_d;
            len_q     <= len_d;
            tdi_q     <= tdi_d;
            rsp_tdo_q <= rsp_tdo_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        div_d     = div_q;
        cnt_d     = cnt_q;
        type_d    = type_q;
        len_d     = len_q;
        tdi_d     = tdi_q;
        rsp_tdo_d = rsp_tdo_q;
        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    type_d    = cmd_type;
                    len_d     = len_c;
                    tdi_d     = cmd_tdi;
                    rsp_tdo_d = '0;
                    div_d     = '0;
                    cnt_d     = '0;
                    if (cmd_type == T_SPIN) state_d = (len_c == '0) ? S_RESP : S_SHIFT;
                    else                    state_d = S_PRE;
                end
            end
            S_PRE, S_SHIFT, S_POST: begin
                div_d = slot_end ? '0 : div_q + 1'b1;
                // tdo is taken on the edge that raises tck, a half period after the TAP drove it.
                if (state_q == S_SHIFT && is_scan && sample) rsp_tdo_d[cnt_q[IW-1:0]] = tdo;
                if (slot_end) begin
                    cnt_d = cnt_q + 1'b1;
                    if (cnt_q == phase_last) begin
                        cnt_d   = '0;
                        state_d = phase_next;
                    end
                end
            end
            S_RESP:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        tck       = 1'b0;
        tms       = 1'b1;
        tdi       = 1'b0;
        case (state_q)
            S_IDLE: cmd_ready = 1'b1;
            S_PRE: begin
                tck = tck_hi;
                tms = (cnt_q < pre_ones);
            end
            S_SHIFT: begin
                tck = tck_hi;
                tms = is_scan && (cnt_q == phase_last);
                tdi = is_scan && tdi_q[cnt_q[IW-1:0]];
            end
            S_POST: begin
                tck = tck_hi;
                tms = (cnt_q < (len_zero ? CW'(2) : CW'(1)));
            end
            S_RESP: rsp_valid = 1'b1;
            default: ;
        endcase
    end

    assign busy    = ~cmd_ready;
    assign rsp_tdo = rsp_tdo_q;

endmodule

// File: tb/tb_jtag_master.sv
// Bench for jtag_master: a behavioural TAP with an IDCODE DR and a command-level model that
// predicts each command's tms/tdi slot stream, captured TDO and response latency.
module tb_jtag_master;

    localparam int MAX_LEN = 64;
    localparam int D       = 3;
    localparam int LW      = 7;
    localparam logic [31:0] IDCODE = 32'h149511c3;
    localparam logic [3:0]  IRCAP  = 4'b0001;

    logic               clk = 1'b0;
    logic               reset_ = 1'b1;
    logic               cmd_valid = 1'b0;
    logic               cmd_ready;
    logic [1:0]         cmd_type = '0;
    logic [LW-1:0]      cmd_len = '0;
    logic [MAX_LEN-1:0] cmd_tdi = '0;
    logic               rsp_valid;
    logic [MAX_LEN-1:0] rsp_tdo;
    logic               busy, tck, tms, tdi;
    logic               tdo = 1'b0;

    jtag_master #(.MAX_LEN(MAX_LEN), .TCK_DIV(D)) dut (
        .clk(clk), .reset_(reset_),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_type(cmd_type),
        .cmd_len(cmd_len), .cmd_tdi(cmd_tdi),
        .rsp_valid(rsp_valid), .rsp_tdo(rsp_tdo), .busy(busy),
        .tck(tck), .tms(tms), .tdi(tdi), .tdo(tdo)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural TAP ----------------
    typedef enum int {
        TAP_TLR, TAP_RTI, TAP_SEL_DR, TAP_CAP_DR, TAP_SH_DR, TAP_EX1_DR, TAP_PA_DR, TAP_EX2_DR,
        TAP_UPD_DR, TAP_SEL_IR, TAP_CAP_IR, TAP_SH_IR, TAP_EX1_IR, TAP_PA_IR, TAP_EX2_IR, TAP_UPD_IR
    } tap_t;

    function automatic tap_t tap_next(input tap_t s, input logic m);
        case (s)
            TAP_TLR:    return m ? TAP_TLR    : TAP_RTI;
            TAP_RTI:    return m ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_DR: return m ? TAP_SEL_IR : TAP_CAP_DR;
            TAP_CAP_DR: return m ? TAP_EX1_DR : TAP_SH_DR;
            TAP_SH_DR:  return m ? TAP_EX1_DR : TAP_SH_DR;
            TAP_EX1_DR: return m ? TAP_UPD_DR : TAP_PA_DR;
            TAP_PA_DR:  return m ? TAP_EX2_DR : TAP_PA_DR;
            TAP_EX2_DR: return m ? TAP_UPD_DR : TAP_SH_DR;
            TAP_UPD_DR: return m ? TAP_SEL_DR : TAP_RTI;
            TAP_SEL_IR: return m ? TAP_TLR    : TAP_CAP_IR;
            TAP_CAP_IR: return m ? TAP_EX1_IR : TAP_SH_IR;
            TAP_SH_IR:  return m ? TAP_EX1_IR : TAP_SH_IR;
            TAP_EX1_IR: return m ? TAP_UPD_IR : TAP_PA_IR;
            TAP_PA_IR:  return m ? TAP_EX2_IR : TAP_PA_IR;
            TAP_EX2_IR: return m ? TAP_UPD_IR : TAP_SH_IR;
            TAP_UPD_IR: return m ? TAP_SEL_DR : TAP_RTI;
            default:    return TAP_TLR;
        endcase
    endfunction

    tap_t         tap = TAP_RTI;
    logic [31:0]  dr_sr = '0;
    logic [3:0]   ir_sr = '0;
    logic [127:0] seen_tms = '0, seen_tdi = '0;
    int           seen_n = 0;

    always @(posedge tck) begin
        if (seen_n < 128) begin
            seen_tms[seen_n] = tms;
            seen_tdi[seen_n] = tdi;
        end
        seen_n++;
        case (tap)
            TAP_CAP_DR: dr_sr = IDCODE;
            TAP_SH_DR:  dr_sr = {tdi, dr_sr[31:1]};
            TAP_CAP_IR: ir_sr = IRCAP;
            TAP_SH_IR:  ir_sr = {tdi, ir_sr[3:1]};
            default: ;
        endcase
        tap = tap_next(tap, tms);
    end

    always @(negedge tck) begin
        if (tap == TAP_SH_DR)      tdo = dr_sr[0];
        else if (tap == TAP_SH_IR) tdo = ir_sr[0];
        else                       tdo = 1'b0;
    end

    // ---------------- command-level model ----------------
    function automatic int clamp_len(input logic [LW-1:0] l);
        return (int'(l) > MAX_LEN) ? MAX_LEN : int'(l);
    endfunction

    // Expected tms/tdi per TCK slot, derived from the TAP path each command must walk.
    task automatic build_slots(input logic [1:0] t, input int l, input logic [63:0] d,
                               output logic [127:0] tv, output logic [127:0] dv, output int n);
        tv = '0; dv = '0; n = 0;
        if (t <= 2'd1) begin
            tv[n] = 1'b1; n++;
            if (t == 2'd0) begin tv[n] = 1'b1; n++; end
            tv[n] = 1'b0; n++;
            if (l == 0) begin
                tv[n] = 1'b1; n++;
            end else begin
                tv[n] = 1'b0; n++;
                for (int i = 0; i < l; i++) begin
                    tv[n] = (i == l - 1);
                    dv[n] = d[i];
                    n++;
                end
            end
            tv[n] = 1'b1; n++;
            tv[n] = 1'b0; n++;
        end else if (t == 2'd2) begin
            for (int i = 0; i < 5; i++) begin tv[n] = 1'b1; n++; end
            tv[n] = 1'b0; n++;
        end else begin
            n = l;
        end
    endtask

    // Captured bits: the register's capture value first, then the bits shifted in from tdi.
    function automatic logic [63:0] model_tdo(input logic [1:0] t, input int l, input logic [63:0] d);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < l; i++) begin
            if (t == 2'd1) begin
                if (i < 32) r[i] = IDCODE[i];
                else        r[i] = d[i-32];
            end else if (t == 2'd0) begin
                if (i < 4) r[i] = IRCAP[i];
                else       r[i] = d[i-4];
            end
        end
        return r;
    endfunction

    logic [63:0]  exp_q[$];
    logic [127:0] exp_tms_q[$];
    logic [127:0] exp_tdi_q[$];
    int           exp_n_q[$];

    int ncyc = 0, acc_cyc = 0, last_rsp_cyc = 0, last_lat = 0, last_seen = 0;
    int rsp_cnt = 0, n_acc = 0, hi_cnt = 0, want_rsp = 0;
    logic         b2b_chk = 1'b0;
    logic [63:0]  last_tdo = '0, last_rsp_tdo = '0;

    // Single compare process: protocol rules every cycle, full response check on rsp_valid.
    always @(negedge clk) begin
        logic [127:0] tv, dv;
        int           n;
        ncyc++;
        if (reset_) begin
            hi_cnt = 0;
        end else begin
            check("busy_vs_ready", busy, !cmd_ready);
            if (tck) hi_cnt++;
            else begin
                if (hi_cnt != 0) check("tck_high_cycles", hi_cnt, D);
                hi_cnt = 0;
            end
            if (cmd_ready || rsp_valid) check("tck_low_outside_cmd", tck, 1'b0);
            if (rsp_valid) begin
                if (exp_n_q.size() == 0) begin
                    check("rsp_unexpected", rsp_valid, 1'b0);
                end else begin
                    n = exp_n_q.pop_front();
                    tv = exp_tms_q.pop_front();
                    dv = exp_tdi_q.pop_front();
                    last_tdo = exp_q.pop_front();
                    check("latency", ncyc - acc_cyc, n * 2 * D + 1);
                    check("rsp_tdo", rsp_tdo, last_tdo);
                    check("tck_slots", seen_n, n);
                    check("tms_stream", seen_tms, tv);
                    check("tdi_stream", seen_tdi, dv);
                    check("tap_in_rti", tap, TAP_RTI);
                    last_lat     = ncyc - acc_cyc;
                    last_seen    = seen_n;
                    last_rsp_tdo = rsp_tdo;
                    last_rsp_cyc = ncyc;
                    rsp_cnt++;
                end
            end else if (cmd_ready) begin
                check("rsp_tdo_hold", rsp_tdo, last_tdo);
            end
            if (cmd_valid && cmd_ready) begin
                build_slots(cmd_type, clamp_len(cmd_len), cmd_tdi, tv, dv, n);
                if (cmd_type == 2'd3) last_tdo = '0;
                exp_q.push_back(model_tdo(cmd_type, clamp_len(cmd_len), cmd_tdi));
                exp_tms_q.push_back(tv);
                exp_tdi_q.push_back(dv);
                exp_n_q.push_back(n);
                if (b2b_chk) begin
                    check("b2b_accept_cycle", ncyc, last_rsp_cyc + 1);
                    b2b_chk = 1'b0;
                end
                acc_cyc = ncyc;
                n_acc++;
                seen_n = 0;
                seen_tms = '0;
                seen_tdi = '0;
            end
        end
    end

    // ---------------- drivers ----------------
    task automatic send(input logic [1:0] t, input int len, input logic [63:0] d);
        int k;
        cmd_type  = t;
        cmd_len   = LW'(len);
        cmd_tdi   = d;
        cmd_valid = 1'b1;
        for (k = 0; k < 5000; k++) begin
            @(negedge clk);
            if (cmd_ready) break;
        end
        check("accept_wait", cmd_ready, 1'b1);
        @(posedge clk); #1;
    endtask

    task automatic wait_rsp();
        int k;
        want_rsp++;
        for (k = 0; k < 5000; k++) begin
            if (rsp_cnt >= want_rsp) break;
            @(negedge clk); #1;
        end
        check("rsp_wait", rsp_cnt >= want_rsp, 1'b1);
        cmd_valid = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc0, k;
        repeat (3) @(posedge clk);
        #1;
        check("rst_tck", tck, 1'b0);
        check("rst_tms", tms, 1'b1);
        check("rst_tdi", tdi, 1'b0);
        check("rst_cmd_ready", cmd_ready, 1'b1);
        check("rst_busy", busy, 1'b0);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_tdo", rsp_tdo, 64'h0);
        reset_ = 1'b0;
        @(posedge clk); #1;

        send(2'd0, 4, 64'h1); cmd_valid = 1'b0; wait_rsp();
        check("ir4_tdo_lit", last_rsp_tdo, 64'h1);
        check("ir4_latency_lit", last_lat, 10 * 2 * D + 1);

        send(2'd1, 32, {$urandom(), $urandom()}); cmd_valid = 1'b0; wait_rsp();
        check("idcode_lit", last_rsp_tdo, 64'h149511c3);
        check("dr32_latency_lit", last_lat, 37 * 2 * D + 1);

        send(2'd1, 0, '1); cmd_valid = 1'b0; wait_rsp();
        check("dr0_tdo_lit", last_rsp_tdo, 64'h0);
        check("dr0_slots_lit", last_seen, 5);
        send(2'd2, 37, '1); cmd_valid = 1'b0; wait_rsp();
        check("tlr_latency_lit", last_lat, 6 * 2 * D + 1);

        send(2'd1, 100, 64'hA5C30F96_12345678); cmd_valid = 1'b0; wait_rsp();
        check("clamp_tdo_lit", last_rsp_tdo, 64'h12345678_149511c3);
        check("clamp_slots_lit", last_seen, 69);

        send(2'd3, 0, '1); cmd_valid = 1'b0; wait_rsp();
        check("spin0_latency_lit", last_lat, 1);
        check("spin0_no_tck_lit", last_seen, 0);
        send(2'd3, 7, '1); cmd_valid = 1'b0; wait_rsp();
        check("spin7_latency_lit", last_lat, 7 * 2 * D + 1);

        send(2'd0, 10, 64'h3A5); cmd_valid = 1'b0; wait_rsp();
        check("ir10_tdo_lit", last_rsp_tdo, 64'h251);

        acc0 = n_acc;
        send(2'd1, 8, 64'hC3); wait_rsp();
        repeat (4) @(posedge clk);
        #1;
        check("held_valid_one_accept", n_acc - acc0, 1);

        send(2'd1, 32, 64'h0);
        b2b_chk = 1'b1;
        send(2'd1, 16, 64'hBEEF);
        cmd_valid = 1'b0;
        wait_rsp();
        wait_rsp();
        check("b2b_tdo_lit", last_rsp_tdo, 64'h11c3);

        send(2'd1, 32, 64'hFFFF0000);
        cmd_valid = 1'b0;
        repeat (30) @(negedge clk);
        for (k = 0; k < 50; k++) begin
            if (tck) break;
            @(negedge clk);
        end
        #1;
        reset_ = 1'b1;
        #1;
        check("abort_tck", tck, 1'b0);
        check("abort_tms", tms, 1'b1);
        check("abort_cmd_ready", cmd_ready, 1'b1);
        check("abort_rsp_valid", rsp_valid, 1'b0);
        check("abort_rsp_tdo", rsp_tdo, 64'h0);
        exp_q.delete();
        exp_tms_q.delete();
        exp_tdi_q.delete();
        exp_n_q.delete();
        last_tdo = '0;
        acc0 = rsp_cnt;
        repeat (3) @(posedge clk);
        #1;
        reset_ = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("abort_no_rsp", rsp_cnt, acc0);
        want_rsp = rsp_cnt;

        send(2'd2, 0, '0); cmd_valid = 1'b0; wait_rsp();
        send(2'd1, 32, 64'h0); cmd_valid = 1'b0; wait_rsp();
        check("post_abort_idcode_lit", last_rsp_tdo, 64'h149511c3);

        repeat (5) @(posedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/jtag_master.md
Name: jtag_master

Overview:
- Synthesizable JTAG host engine: the initiator side of the TAP protocol our icetap TAP responds to.
- Takes scan commands (IR scan, DR scan, TAP reset, idle spin) from on-chip logic such as a UART bridge or a self-test sequencer.
- Generates tck/tms/tdi, walks the TAP state machine from and back to Run-Test/Idle, and returns the captured TDO vector.
- Lets the same design host both the logic-analyzer TAP and its controller, without an external probe.

Parameters:
- MAX_LEN, 64, maximum shift length in bits; also width of cmd_tdi and rsp_tdo.
- TCK_DIV, 4, clk cycles per TCK half-period (must be >= 1); TCK period = 2*TCK_DIV clk cycles.

Ports:
- clk  in  1  system clock
- reset_  in  1  reset, asynchronous, active-high
- cmd_valid  in  1  command request
- cmd_ready  out  1  engine idle, command accepted when cmd_valid && cmd_ready
- cmd_type  in  2  0=IR scan, 1=DR scan, 2=TAP reset (TLR), 3=idle spin
- cmd_len  in  $clog2(MAX_LEN+1)  shift bits (scans) or TCK count (spin)
- cmd_tdi  in  MAX_LEN  TDI data, bit 0 shifted first
- rsp_valid  out  1  one-cycle pulse, command complete
- rsp_tdo  out  MAX_LEN  captured TDO, bit 0 first captured; bits >= len are 0
- busy  out  1  command in progress (= !cmd_ready)
- tck  out  1  JTAG clock
- tms  out  1  JTAG mode select
- tdi  out  1  JTAG data to TAP
- tdo  in  1  JTAG data from TAP (TAP updates it on TCK falling edge)

Behaviour:
- Reset values:
  - tck=0, tms=1, tdi=0.
  - cmd_ready=1, busy=0.
  - rsp_valid=0, rsp_tdo=0.
- Reset mid-command aborts immediately to these values. No response is issued. The TAP state is undefined afterwards; the user must issue TLR.
- The engine assumes the TAP is in Run-Test/Idle at command start, and always leaves it in Run-Test/Idle.
- States: IDLE, PRE, SHIFT, POST, RESP.
- IDLE:
  - cmd_ready=1, tck held 0.
  - On accept: latch cmd_*, clamp cmd_len>MAX_LEN to MAX_LEN, clear rsp_tdo, go to PRE.
- TCK bit slot (used by PRE, SHIFT and POST):
  - tms/tdi are updated at slot start, with tck=0 for TCK_DIV cycles.
  - tck=1 for the next TCK_DIV cycles.
  - tdo is sampled on the clk edge that drives tck high.
- PRE tms sequence:
  - DR scan: 1,0,0 (Select-DR, Capture-DR, Shift-DR).
  - IR scan: 1,1,0,0.
  - Scan with len=0: DR 1,0 / IR 1,1,0, then go directly to POST with prefix tms=1 (Capture→Exit1).
- SHIFT:
  - len slots; slot i drives tdi=cmd_tdi[i] and stores the sampled tdo into rsp_tdo[i].
  - tms=0 except the final slot, which uses tms=1 (to Exit1).
- POST: tms 1,0 (Update, Run-Test/Idle), tdi=0.
- TLR command: six slots, tms 1,1,1,1,1,0; ends in Run-Test/Idle. cmd_len is ignored.
- Spin command: len slots with tms=0. len=0 produces no TCK and goes straight to RESP.
- tdi=0 in every non-SHIFT slot.
- RESP:
  - rsp_valid=1 for exactly one cycle, with rsp_tdo stable.
  - Next state IDLE.
  - cmd_ready returns to 1 in the cycle after rsp_valid.
  - rsp_tdo holds its value until the next accept.
  - rsp_valid is always issued (TLR, spin included); rsp_tdo=0 for non-scan commands.
- Latency: (number of slots)*2*TCK_DIV + 1 clk from accept to rsp_valid. Example: DR scan of len N = (N+5)*2*TCK_DIV+1.
- tck is always 0 when the engine is in IDLE/RESP; no partial TCK pulses occur outside reset.
- cmd_valid while busy is ignored and not queued.

Test Plan:
- IR scan len=4 of 4'b0001, TAP model in RTI → tms stream 1,1,0,0,0,0,0,1,1,0; tdi 1,0,0,0 during shift; rsp_tdo=4'b0001 (IR capture pattern); rsp_valid at clk 10*2*TCK_DIV+1 after accept.
- DR scan len=32 with TAP model holding IDCODE 32'h149511c3 → rsp_tdo[31:0]=32'h149511c3, upper bits 0, TAP model back in Run-Test/Idle.
- DR scan len=0 → tms 1,0,1,1,0, no Shift-DR visited, rsp_tdo=0; then TLR → exactly five consecutive tms=1 slots then 0, model in Run-Test/Idle.
- cmd_len=100 with MAX_LEN=64 → exactly 64 shift slots; spin len=0 → rsp_valid 1 cycle after accept, no tck edge; cmd_valid held during busy → exactly one accept.
- Back-to-back: cmd_valid held high with two DR scans → second accept on the cycle cmd_ready rises; tck stays 0 between commands.
- reset_ pulsed mid-SHIFT (TCK_DIV=1 and TCK_DIV=3) → same-cycle tck=0, tms=1, cmd_ready=1, no rsp_valid; following TLR + IDCODE scan succeeds.
